// File: rtl/vm3_mux_tx.sv
// rtl/vm3_mux_tx.sv - VM3 control multiplexer transmitter
// Serializes eight status lines into a 4-slot frame and interleaves DMA lines each bus period.
module vm3_mux_tx #(
  parameter int SYNC = 2
) (
  input  logic       MCLK,
  input  logic       MRST,
  input  logic       nDCLO,
  input  logic       nACLO,
  input  logic       nHALT,
  input  logic       nEVNT,
  input  logic [3:0] nIRQ,
  input  logic       nDMR,
  input  logic       nSACK,
  output logic       MXCLK,
  output logic [1:0] MXIN,
  output logic       MXSTB,
  output logic       FRM
);

  logic [9:0] rawIn;
  logic [9:0] syncQ [SYNC];
  logic [9:0] syncOut;
  logic [7:0] statusS;
  logic [1:0] dmaS;

  logic [3:0] cnt;
  logic [3:0] cntNext;
  logic [7:0] word;
  logic [7:0] wordNext;
  logic [1:0] slotBits;
  logic [1:0] mxinNext;

  assign rawIn   = {nSACK, nDMR, nDCLO, nACLO, nHALT, nEVNT, nIRQ};
  assign syncOut = syncQ[SYNC-1];
  assign statusS = syncOut[7:0];
  assign dmaS    = syncOut[9:8];

  // Synchronizers reset to 1 so every request starts out inactive.
  always_ff @(posedge MCLK) begin
    if (MRST) begin
      for (int i = 0; i < SYNC; i++) syncQ[i] <= '1;
    end else begin
      syncQ[0] <= rawIn;
      for (int i = 1; i < SYNC; i++) syncQ[i] <= syncQ[i-1];
    end
  end

  // Outputs are computed from the phase being entered so they are registered without lag.
  always_comb begin
    cntNext  = cnt + 4'd1;
    wordNext = word;
    if (cntNext == 4'd0) wordNext = statusS;
    case (cntNext[3:2])
      2'd0:    slotBits = wordNext[7:6];
      2'd1:    slotBits = wordNext[5:4];
      2'd2:    slotBits = wordNext[3:2];
      default: slotBits = wordNext[1:0];
    endcase
    mxinNext = MXIN;
    if (!cntNext[1])
      mxinNext = slotBits;
    else if (cntNext[1:0] == 2'd2)
      mxinNext = dmaS;
  end

  always_ff @(posedge MCLK) begin
    if (MRST) begin
      cnt   <= 4'd0;
      word  <= 8'hFF;
      MXCLK <= 1'b0;
      MXIN  <= 2'b11;
      MXSTB <= 1'b0;
      FRM   <= 1'b0;
    end else begin
      cnt   <= cntNext;
      word  <= wordNext;
      MXCLK <= cntNext[1] ^ cntNext[0];
      MXIN  <= mxinNext;
      MXSTB <= (cntNext[3:2] == 2'd3) && !cntNext[1];
      FRM   <= (cntNext == 4'd0);
    end
  end

endmodule

// File: tb/tb_vm3_mux_tx.sv
// tb/tb_vm3_mux_tx.sv - directed and random bench for vm3_mux_tx
// Includes a model receiver capturing mux on MXCLK rise with MXSTB and dmr on MXCLK fall.
module tb_vm3_mux_tx;

  logic       MCLK = 1'b0;
  logic       MRST = 1'b1;
  logic       nDCLO = 1'b0, nACLO = 1'b0, nHALT = 1'b0, nEVNT = 1'b0;
  logic [3:0] nIRQ = 4'h0;
  logic       nDMR = 1'b0, nSACK = 1'b0;
  logic       MXCLK;
  logic [1:0] MXIN;
  logic       MXSTB;
  logic       FRM;

  vm3_mux_tx #(.SYNC(2)) dut (
    .MCLK(MCLK), .MRST(MRST),
    .nDCLO(nDCLO), .nACLO(nACLO), .nHALT(nHALT), .nEVNT(nEVNT), .nIRQ(nIRQ),
    .nDMR(nDMR), .nSACK(nSACK),
    .MXCLK(MXCLK), .MXIN(MXIN), .MXSTB(MXSTB), .FRM(FRM)
  );

  always #5 MCLK = ~MCLK;

  logic       prevClk = 1'b0;
  logic [5:0] rxSr = '0;
  logic [7:0] rxMux = '0;
  logic [1:0] rxDmr = '0;
  int         muxUpd = 0;

  always @(negedge MCLK) begin
    if (MXCLK && !prevClk) begin
      rxSr <= {rxSr[3:0], MXIN};
      if (MXSTB) begin
        rxMux  <= {rxSr, MXIN};
        muxUpd <= muxUpd + 1;
      end
    end
    if (!MXCLK && prevClk) rxDmr <= MXIN;
    prevClk <= MXCLK;
  end

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge MCLK);
    #1;
  endtask

  task automatic setStatus(input logic [7:0] s);
    {nDCLO, nACLO, nHALT, nEVNT, nIRQ} = s;
  endtask

  task automatic waitFrm;
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!FRM && k < 40);
    if (!FRM) checkVal("frm_timeout", 0, 1);
  endtask

  logic [1:0] expSeq [4];
  logic [7:0] sCur, sPrev;
  logic [1:0] dCur, dPrev;
  logic       v, vPrev;
  int         n, lat, seen, m0, firstStb;

  initial begin
    expSeq = '{2'b10, 2'b10, 2'b01, 2'b01};

    // reset with all inputs low
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal("rst_mxin", MXIN, 2'b11);
      checkVal("rst_mxstb", MXSTB, 0);
      checkVal("rst_mxclk", MXCLK, 0);
      checkVal("rst_frm", FRM, 0);
    end
    MRST = 1'b0;
    m0 = muxUpd;
    n = 0;
    do begin tick(); n++; end while (!FRM && n < 40);
    checkVal("first_frm_dist", n, 16);
    checkVal("first_mux_upd", muxUpd, m0 + 1);
    checkVal("first_mux_ff", rxMux, 8'hFF);

    // frame encoding of A5
    setStatus(8'hA5);
    nDMR = 1'b1;
    nSACK = 1'b1;
    waitFrm();
    waitFrm();
    for (int i = 0; i < 16; i++) begin
      checkVal("enc_mxclk", MXCLK, ((i % 4) == 1) || ((i % 4) == 2));
      checkVal("enc_mxstb", MXSTB, ((i / 4) == 3) && ((i % 4) < 2));
      if ((i % 4) < 2) checkVal("enc_data", MXIN, expSeq[i / 4]);
      else             checkVal("enc_dma", MXIN, 2'b11);
      tick();
    end
    checkVal("enc_frm", FRM, 1);
    checkVal("enc_mux", rxMux, 8'hA5);

    // DMA channel latency and steady value
    nDMR = 1'b0;
    nSACK = 1'b1;
    n = 0;
    do begin tick(); n++; end while (rxDmr !== 2'b10 && n < 20);
    checkVal("dma_lat_ok", n <= 8, 1);
    checkVal("dma_val", rxDmr, 2'b10);
    waitFrm();
    for (int i = 0; i < 16; i++) begin
      if ((i % 4) >= 2) checkVal("dma_half", MXIN, 2'b10);
      tick();
    end

    // nDMR toggled every period; each period carries the previous period's sample
    waitFrm();
    vPrev = 1'b0;
    for (int p = 0; p < 8; p++) begin
      v = p[0];
      nDMR = v;
      tick();
      tick();
      checkVal("tog_mx_ph2", MXIN, {1'b1, vPrev});
      tick();
      checkVal("tog_mx_ph3", MXIN, {1'b1, vPrev});
      checkVal("tog_rx", rxDmr, {1'b1, vPrev});
      tick();
      vPrev = v;
    end

    // nIRQ[0] falls at slot 1
    nDMR = 1'b1;
    waitFrm();
    for (int i = 0; i < 4; i++) tick();
    nIRQ[0] = 1'b0;
    m0 = muxUpd;
    seen = 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 8)  checkVal("mid_old_slot3", MXIN, 2'b01);
      if (k == 24) checkVal("mid_new_slot3", MXIN, 2'b00);
      if (muxUpd != m0 + seen) begin
        seen++;
        if (seen == 1) checkVal("mid_mux_old", rxMux, 8'hA5);
        if (seen == 2) begin
          checkVal("mid_mux_new", rxMux, 8'hA4);
          lat = k;
        end
      end
    end
    checkVal("mid_upd_count", seen, 2);
    checkVal("mid_lat_ok", (lat >= 15) && (lat <= 31), 1);

    // reset at slot 2 ph 1
    waitFrm();
    for (int i = 0; i < 9; i++) tick();
    MRST = 1'b1;
    m0 = muxUpd;
    tick();
    checkVal("mrst_mxin", MXIN, 2'b11);
    checkVal("mrst_mxstb", MXSTB, 0);
    checkVal("mrst_mxclk", MXCLK, 0);
    checkVal("mrst_frm", FRM, 0);
    MRST = 1'b0;
    n = 0;
    firstStb = -1;
    do begin
      tick();
      n++;
      if (MXSTB && firstStb < 0) firstStb = n;
    end while (!FRM && n < 40);
    checkVal("mrst_frm_dist", n, 16);
    checkVal("mrst_first_stb", firstStb, 12);
    checkVal("mrst_mux_upd", muxUpd, m0 + 1);
    checkVal("mrst_mux_ff", rxMux, 8'hFF);

    // long random run, aligned to frame and period boundaries
    sCur = 8'hA4;
    dCur = {nSACK, nDMR};
    sPrev = sCur;
    dPrev = dCur;
    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < 16; i++) begin
        checkVal("lr_frm", FRM, i == 0);
        if ((i % 4) == 0) begin
          dPrev = dCur;
          dCur = 2'($urandom_range(0, 3));
          {nSACK, nDMR} = dCur;
        end
        if (i == 4) begin
          sPrev = sCur;
          sCur = 8'($urandom);
          setStatus(sCur);
        end
        if ((i % 4) == 3) checkVal("lr_dmr", rxDmr, dPrev);
        if (i == 13) checkVal("lr_mux", rxMux, sPrev);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vm3_mux_tx.md
# vm3_mux_tx

Serial transmitter for the 2-bit control multiplexer feeding the VM3 board's CPU-side interface logic. It runs on a fast clock of 4x the bus clock and generates that bus clock itself as MXCLK. It samples eight slow status lines (nDCLO, nACLO, nHALT, nEVNT, nIRQ[3:0]) and serializes them as a 4-slot framed word on MXIN[1:0] with an MXSTB load strobe. In the second half of every bus clock period it time-multiplexes the fast DMA lines (nDMR, nSACK) onto the same MXIN pair, to be captured on the falling MXCLK edge.

## Interface
- SYNC, default 2: synchronizer stages on all status/DMA inputs (legal values 2..3).
- MCLK  in  1  fast clock, 4x the MXCLK rate; all logic on the rising edge.
- MRST  in  1  synchronous reset, active-high.
- nDCLO  in  1  DC low request, async, active-low; frame bit 7.
- nACLO  in  1  AC low request, async, active-low; frame bit 6.
- nHALT  in  1  halt request, async, active-low; frame bit 5.
- nEVNT  in  1  timer event, async, active-low; frame bit 4.
- nIRQ  in  4  interrupt requests, async, active-low; frame bits 3:0.
- nDMR  in  1  DMA request, async, active-low; sent as MXIN[0] in the DMA half.
- nSACK  in  1  DMA acknowledge, async, active-low; sent as MXIN[1] in the DMA half.
- MXCLK  out  1  generated bus clock for the receiver.
- MXIN  out  2  multiplexed serial data.
- MXSTB  out  1  frame load strobe, high during the last slot.
- FRM  out  1  one-MCLK pulse marking the first cycle of each frame, for debug and bench alignment.

## Operation
- Free-running 4-bit counter cnt: ph = cnt[1:0] is the phase within one MXCLK period; slot = cnt[3:2] is the slot within a frame. One frame is 16 MCLK cycles.
- All outputs are registered. The values below are the register contents during the cycle with the given ph.
- MXCLK = 1 when ph is 1 or 2, otherwise 0. The receiver's rising edge is therefore mid-data and its falling edge is mid-DMA.
- Data half (ph 0 and 1):
  - MXIN = word[7-2*slot : 6-2*slot].
  - MXSTB = (slot == 3).
- DMA half (ph 2 and 3):
  - MXIN = {sack_s, dmr_s}, where sack_s and dmr_s are captured once per period, at the register update that enters ph 2.
  - MXSTB = 0.
- Word capture: word[7:0] = {dclo_s, aclo_s, halt_s, evnt_s, irq_s[3:0]} is loaded from the synchronized inputs on the update that enters slot 0 ph 0.
- word is held constant for the whole frame. Input changes mid-frame appear only in the next frame.
- Synchronizers: SYNC-stage flip-flop chains on every async input. No filtering or edge detection.
- Mapping at the receiver, by construction:
  - After the rising edge in slot 3, the receiver holds {word[7:2], word[1:0]}.
  - On each falling edge it holds dmr = {nSACK, nDMR}.
- FRM = 1 exactly in the cycle with cnt == 0.

## Timing
- Reset (MRST high at a rising MCLK edge) sets:
  - cnt = 0, MXCLK = 0, MXSTB = 0, MXIN = 2'b11, FRM = 0;
  - word = 8'hFF, all synchronizer flops = 1 (all requests inactive).
- In the first cycle after MRST deasserts, cnt = 0 and the first frame starts.
  - That frame carries word = 8'hFF, because word was loaded during reset.
  - FRM pulses on the next cnt == 0, i.e. 16 cycles later.
- Reset mid-frame aborts the frame immediately. MXSTB is never asserted for a partial frame.
- Setup and hold at the receiver are each one MCLK period:
  - data and MXSTB change entering ph 0 and are sampled at the MXCLK rise (entering ph 1);
  - DMA data changes entering ph 2 and is sampled at the MXCLK fall (entering ph 3 to 0).
- Status latency, from an input edge to the receiver's register update: at most SYNC + 16 + 13 MCLK cycles, at least SYNC + 13.
- DMA latency, from an input edge to the receiver dmr update: at most SYNC + 4 + 2 MCLK cycles.
- Simultaneous changes:
  - A status input changing in the same cycle as the word load is taken as its synchronized value at that edge; no glitch within a frame.
  - nDMR and nSACK are captured together and never split across periods.
- cnt wraps from 15 to 0 with no gap; frames are back-to-back.

## Test plan
- Reset: hold MRST for 3 cycles with all inputs 0. Require MXIN = 11, MXSTB = 0, MXCLK = 0 during reset. The first frame after release must carry word FF.
- Frame encoding: set status inputs so word = 8'hA5 and let it settle for one frame. The data-half MXIN sequence across slots must be 10, 10, 01, 01, with MXSTB high only in slot 3. A bench model receiver must hold mux = A5.
- DMA channel: nDMR = 0, nSACK = 1. MXIN must be 10 in every ph 2 and 3, and the model receiver must hold dmr = 2'b10 within SYNC + 6 cycles. Toggle nDMR every 4 cycles and check that every period follows it.
- Mid-frame change: change nIRQ[0] from 1 to 0 at slot 1. The current frame's slot-3 data must still show the old bit. The next frame must show the new bit. Measured latency must lie within the bounds above.
- Reset mid-frame: assert MRST at slot 2 ph 1. There must be no MXSTB pulse, and the outputs must equal the reset values in the following cycle. Normal framing must resume with cnt = 0.
- Long run: 1000 frames of random status and DMA inputs against the model receiver, with a scoreboard checking every mux and dmr update.
